// File: rtl/apb_req_arbiter_if.sv
// APB bus between the request arbiter (master) and a single APB slave.
// Widths must match the arbiter's A_WIDTH/D_WIDTH parameters.
interface apb_req_arbiter_if #(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 8
);
    logic               p_sel;
    logic               p_enable;
    logic               p_write;
    logic [A_WIDTH-1:0] p_addr;
    logic [D_WIDTH-1:0] wr_data;
    logic [D_WIDTH-1:0] rd_data;
    logic               p_ready;
    logic               p_slverr;

    modport master (
        output p_sel, p_enable, p_write, p_addr, wr_data,
        input  rd_data, p_ready, p_slverr
    );

    modport slave (
        input  p_sel, p_enable, p_write, p_addr, wr_data,
        output rd_data, p_ready, p_slverr
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin APB master shared by NUM_REQ requesters; min 3 cycles request-to-done, +1 per wait state.
// Backpressure: p_ready low holds ACCESS (bounded by TIMEOUT); requests are level and wait until granted.
module apb_req_arbiter #(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 8,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                       p_clk,
    input  logic                       p_rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ*A_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*D_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]         done,
    output logic [D_WIDTH-1:0]         rsp_rdata,
    output logic                       rsp_err,
    apb_req_arbiter_if.master          apb
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    typedef struct packed {
        logic               write;
        logic [A_WIDTH-1:0] addr;
        logic [D_WIDTH-1:0] wdata;
    } xfer_t;

    state_t             state_q, state_d;
    xfer_t              xfer_q;
    logic               p_sel_q, p_enable_q;
    logic [GW-1:0]      last_grant, grant_q, winner;
    logic               win_vld;
    logic [NUM_REQ-1:0] eligible;
    logic [CW-1:0]      wait_cnt;
    logic               complete, timed_out;
    logic [NUM_REQ-1:0] done_q;
    logic [D_WIDTH-1:0] rdata_q;
    logic               err_q;

    function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int off);
        int s;
        s = (int'(base) + off) % NUM_REQ;
        return GW'(s);
    endfunction

    // The requester completing this cycle is masked so others get a turn first.
    assign eligible = req & ~done_q;

    always_comb begin
        winner  = last_grant;
        win_vld = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!win_vld && eligible[rr_idx(last_grant, i)]) begin
                win_vld = 1'b1;
                winner  = rr_idx(last_grant, i);
            end
        end
    end

    always_ff @(posedge p_clk or posedge p_rst) begin
        if (p_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        complete  = 1'b0;
        timed_out = 1'b0;
        unique case (state_q)
            IDLE:   if (win_vld) state_d = SETUP;
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (apb.p_ready) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else if (TIMEOUT > 0 && wait_cnt == CW'(TIMEOUT - 1)) begin
                    // This stalled cycle is the TIMEOUT-th one: abort now.
                    complete  = 1'b1;
                    timed_out = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge p_clk or posedge p_rst) begin
        if (p_rst) begin
            xfer_q     <= '0;
            p_sel_q    <= 1'b0;
            p_enable_q <= 1'b0;
            last_grant <= GW'(NUM_REQ - 1);
            grant_q    <= '0;
            wait_cnt   <= '0;
            done_q     <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            p_sel_q    <= (state_d != IDLE);
            p_enable_q <= (state_d == ACCESS);
            done_q     <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;

            if (state_q == IDLE && win_vld) begin
                grant_q      <= winner;
                last_grant   <= winner;
                xfer_q.write <= req_write[winner];
                xfer_q.addr  <= req_addr[winner*A_WIDTH +: A_WIDTH];
                xfer_q.wdata <= req_wdata[winner*D_WIDTH +: D_WIDTH];
            end

            if (state_q == SETUP)
                wait_cnt <= '0;
            else if (state_q == ACCESS && !apb.p_ready)
                wait_cnt <= wait_cnt + CW'(1);

            if (complete) begin
                done_q  <= NUM_REQ'(1) << grant_q;
                err_q   <= timed_out | apb.p_slverr;
                rdata_q <= (timed_out || xfer_q.write) ? '0 : apb.rd_data;
            end
        end
    end

    assign apb.p_sel    = p_sel_q;
    assign apb.p_enable = p_enable_q;
    assign apb.p_write  = xfer_q.write;
    assign apb.p_addr   = xfer_q.addr;
    assign apb.wr_data  = xfer_q.wdata;
    assign done         = done_q;
    assign rsp_rdata    = rdata_q;
    assign rsp_err      = err_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter: stimulus queues expected APB phases and completions,
// a negedge monitor pops and compares whenever the DUT shows a SETUP phase or a done pulse.
module tb_apb_req_arbiter;
    logic       p_clk = 1'b0;
    logic       p_rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] req_write = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0] done;
    logic [7:0] rsp_rdata;
    logic       rsp_err;

    apb_req_arbiter_if #(.A_WIDTH(8), .D_WIDTH(8)) apb ();

    apb_req_arbiter #(.A_WIDTH(8), .D_WIDTH(8), .NUM_REQ(4), .TIMEOUT(16)) dut (
        .p_clk(p_clk), .p_rst(p_rst), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .done(done),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .apb(apb)
    );

    always #5 p_clk = ~p_clk;

    typedef struct { logic [7:0] addr; logic wr; logic [7:0] wdata; } apb_exp_t;
    typedef struct { logic [3:0] done; logic [7:0] rdata; logic err; int cyc; } done_exp_t;

    apb_exp_t  apb_q[$];
    done_exp_t done_q[$];
    apb_exp_t  cur;
    bit        have_cur = 0;
    int        tests = 0;
    int        fails = 0;
    int        cyc = 0;

    int         cfg_waits = 0;
    bit         cfg_hang = 0;
    bit         cfg_err = 0;
    logic [7:0] cfg_rdata = 8'h00;
    int         waits_left = 0;

    always @(posedge p_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave model: wait states, error and read data come from cfg_*; outside the completion
    // cycle it drives junk on rd_data/p_slverr that must not reach the response.
    initial begin
        apb.p_ready = 1'b0; apb.rd_data = 8'hEE; apb.p_slverr = 1'b1;
        forever begin
            @(negedge p_clk);
            if (apb.p_sel && !apb.p_enable) waits_left = cfg_waits;
            if (apb.p_sel && apb.p_enable) begin
                if (cfg_hang || waits_left > 0) begin
                    apb.p_ready = 1'b0; apb.rd_data = 8'hEE; apb.p_slverr = 1'b1;
                    if (waits_left > 0) waits_left--;
                end else begin
                    apb.p_ready = 1'b1; apb.rd_data = cfg_rdata; apb.p_slverr = cfg_err;
                end
            end else begin
                apb.p_ready = 1'b1; apb.rd_data = 8'hEE; apb.p_slverr = 1'b1;
            end
        end
    end

    // Monitor
    initial begin
        done_exp_t d;
        forever begin
            @(negedge p_clk);
            if (!p_rst) begin
                if (apb.p_sel && !apb.p_enable) begin
                    if (apb_q.size() == 0) begin
                        fails++; tests++;
                        $display("FAIL unexpected_setup: addr 0x%0h, none expected", apb.p_addr);
                    end else begin
                        cur = apb_q.pop_front(); have_cur = 1;
                        chk("setup_addr", apb.p_addr, cur.addr);
                        chk("setup_write", apb.p_write, cur.wr);
                        chk("setup_wdata", apb.wr_data, cur.wdata);
                    end
                end
                if (apb.p_enable && have_cur) begin
                    chk("access_sel", apb.p_sel, 1);
                    chk("access_addr_stable", apb.p_addr, cur.addr);
                    chk("access_write_stable", apb.p_write, cur.wr);
                    chk("access_wdata_stable", apb.wr_data, cur.wdata);
                end
                if (done != 0) begin
                    if (done_q.size() == 0) begin
                        fails++; tests++;
                        $display("FAIL unexpected_done: got 0x%0h, none expected", done);
                    end else begin
                        d = done_q.pop_front();
                        chk("done_onehot", done, d.done);
                        chk("rsp_rdata", rsp_rdata, d.rdata);
                        chk("rsp_err", rsp_err, d.err);
                        chk("done_fsm_idle", {apb.p_sel, apb.p_enable}, 2'b00);
                        if (d.cyc >= 0) chk("done_latency_cycle", cyc, d.cyc);
                    end
                end else begin
                    chk("idle_rsp_zero", {rsp_rdata, rsp_err}, 9'h0);
                end
            end
        end
    end

    task automatic issue(input int i, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                         input int waits, input logic [7:0] rdv, input bit serr, input bit hang,
                         input logic [3:0] e_done, input logic [7:0] e_rdata, input bit e_err,
                         input int e_lat);
        apb_exp_t  ae;
        done_exp_t de;
        cfg_waits = waits; cfg_rdata = rdv; cfg_err = serr; cfg_hang = hang;
        req_write[i] = wr;
        req_addr[i*8 +: 8] = a;
        req_wdata[i*8 +: 8] = wd;
        ae = '{a, wr, wd};
        apb_q.push_back(ae);
        de = '{e_done, e_rdata, e_err, cyc + e_lat};
        done_q.push_back(de);
        req[i] = 1'b1;
        @(posedge p_clk); #1;
        // Granted now; later input changes and dropping req must not affect the transfer.
        req[i] = 1'b0;
        req_addr[i*8 +: 8] = 8'hFF;
        req_wdata[i*8 +: 8] = 8'h00;
        req_write[i] = ~wr;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((apb_q.size() != 0 || done_q.size() != 0) && n < budget) begin
            @(negedge p_clk); #1; n++;
        end
        chk({name, "_drain_timeout"}, apb_q.size() + done_q.size(), 0);
        apb_q.delete(); done_q.delete();
        @(posedge p_clk); #1;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_psel"}, apb.p_sel, 0);
        chk({name, "_penable"}, apb.p_enable, 0);
        chk({name, "_pwrite"}, apb.p_write, 0);
        chk({name, "_paddr"}, apb.p_addr, 0);
        chk({name, "_wrdata"}, apb.wr_data, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_rsp"}, {rsp_rdata, rsp_err}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #12;
        chk_reset_outputs("reset");
        @(posedge p_clk); #1;
        p_rst = 1'b0;
        @(posedge p_clk); #1;

        // Single write, zero wait
        issue(0, 1, 8'h45, 8'hA5, 0, 8'h00, 0, 0, 4'b0001, 8'h00, 0, 3);
        drain("write", 20);
        // Read with 3 wait states
        issue(2, 0, 8'h65, 8'h11, 3, 8'h3C, 0, 0, 4'b0100, 8'h3C, 0, 6);
        drain("read_wait", 20);
        // Slave error on read: data still returned
        issue(1, 0, 8'h94, 8'h22, 0, 8'h5A, 1, 0, 4'b0010, 8'h5A, 1, 3);
        drain("slverr", 20);
        // Error-free write with wait states returns zero data
        issue(3, 1, 8'hC3, 8'h7E, 2, 8'h99, 0, 0, 4'b1000, 8'h00, 0, 5);
        drain("write_wait", 20);
        // Hung slave: 16 ACCESS cycles then abort
        issue(3, 0, 8'h0F, 8'h33, 0, 8'h44, 0, 1, 4'b1000, 8'h00, 1, 18);
        drain("timeout", 40);
        issue(0, 1, 8'h12, 8'h34, 0, 8'h00, 0, 0, 4'b0001, 8'h00, 0, 3);
        drain("after_timeout", 20);

        // Reset while in ACCESS: no done, transfer lost
        cfg_waits = 5; cfg_hang = 0;
        req_write[1] = 1'b0; req_addr[15:8] = 8'h5D; req_wdata[15:8] = 8'h66;
        apb_q.push_back('{8'h5D, 1'b0, 8'h66});
        req[1] = 1'b1;
        @(posedge p_clk); #1;
        req[1] = 1'b0;
        n = 0;
        while (!apb.p_enable && n < 10) begin @(negedge p_clk); n++; end
        chk("reach_access_before_reset", apb.p_enable, 1);
        #2 p_rst = 1'b1;
        #1;
        chk("async_reset_psel", apb.p_sel, 0);
        chk("async_reset_penable", apb.p_enable, 0);
        have_cur = 0;
        @(posedge p_clk); @(posedge p_clk); #1;
        chk_reset_outputs("midreset");
        p_rst = 1'b0;
        repeat (3) @(posedge p_clk);
        #1;
        chk("no_done_after_reset", done, 0);
        drain("midreset", 5);

        // Round-robin with all four held: order 0,1,2,3,0,1,2,3, done every 3 cycles
        cfg_waits = 0; cfg_hang = 0; cfg_err = 0; cfg_rdata = 8'h77;
        req_write = 4'b0101;
        req_addr = 32'h44_33_22_11;
        req_wdata = 32'hD3_C2_B1_A0;
        for (int j = 0; j < 8; j++) begin
            int k;
            k = j % 4;
            apb_q.push_back('{req_addr[k*8 +: 8], req_write[k], req_wdata[k*8 +: 8]});
            done_q.push_back('{4'(1 << k), (req_write[k] ? 8'h00 : 8'h77), 1'b0, cyc + 3 + 3*j});
        end
        req = 4'hF;
        n = 0;
        while (apb_q.size() != 0 && n < 40) begin @(negedge p_clk); #1; n++; end
        req = 4'h0;
        drain("round_robin", 40);
        repeat (4) @(posedge p_clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
